// File: rtl/mole_pkg.sv
// mole_pkg: shared types, constants and mole-up timing helper for the round controller.
package mole_pkg;
    typedef enum logic [2:0] {IDLE, SPAWN, UP, PENALTY, DONE} state_e;
    localparam int unsigned RETRY_LIMIT = 4;
    localparam int unsigned LEVEL_W = 3;
    function automatic int unsigned up_ticks(input int unsigned mole_ticks, input int unsigned min_ticks,
                                             input logic [LEVEL_W-1:0] lvl);
        int unsigned t;
        t = mole_ticks >> lvl;
        return (t > min_ticks) ? t : min_ticks;
    endfunction
endpackage

// File: rtl/mole_countdown.sv
// mole_countdown: loadable down-counter that parks at zero and flags it.
module mole_countdown #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         zero_o
);
    logic [W-1:0] cnt_q, cnt_d;
    always_comb cnt_d = load_i ? load_val_i : (cnt_q != '0 ? cnt_q - 1'b1 : cnt_q);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    assign zero_o = (cnt_q == '0);
endmodule

// File: rtl/mole_round_ctrl.sv
// mole_round_ctrl: N-mole whack-a-mole round controller with timeouts, wrong-press
// penalty, release-based lockout and level speed-up.
module mole_round_ctrl
    import mole_pkg::*;
#(
    parameter int unsigned N_MOLES       = 7,
    parameter int unsigned IDX_W         = (N_MOLES > 2) ? $clog2(N_MOLES) : 1,
    parameter int unsigned SCORE_W       = 8,
    parameter int unsigned MOLE_TICKS    = 500000,
    parameter int unsigned MIN_TICKS     = 50000,
    parameter int unsigned PENALTY_TICKS = 100000,
    parameter int unsigned LEVEL_STEP    = 8,
    parameter int unsigned MAX_LEVEL     = 7
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_i,
    input  logic               game_end_i,
    input  logic [IDX_W-1:0]   rand_idx_i,
    input  logic [N_MOLES-1:0] btn_i,
    output logic [N_MOLES-1:0] mole_o,
    output logic [N_MOLES-1:0] lockout_o,
    output logic [SCORE_W-1:0] score_o,
    output logic [SCORE_W-1:0] misses_o,
    output logic [LEVEL_W-1:0] level_o,
    output logic               active_o
);
    localparam int unsigned CNT_W   = $clog2((MOLE_TICKS > PENALTY_TICKS ? MOLE_TICKS : PENALTY_TICKS) + 1);
    localparam int unsigned RETRY_W = $clog2(RETRY_LIMIT);
    localparam logic [SCORE_W-1:0] SAT = '1;

    state_e               state_q, state_d;
    logic [N_MOLES-1:0]   mole_q, mole_d, lockout_q, lockout_d, btn_q, press, wrong, hit;
    logic [SCORE_W-1:0]   score_q, score_d, misses_q, misses_d, score_inc, misses_inc;
    logic [LEVEL_W-1:0]   level_q, level_d;
    logic [IDX_W-1:0]     prev_q, prev_d, idx, next_idx;
    logic [RETRY_W-1:0]   retry_q, retry_d;
    logic [CNT_W-1:0]     cnt_val;
    logic                 cnt_load, cnt_zero, idx_ok, spawn_go, start_ok, lvl_up;

    mole_countdown #(.W(CNT_W)) u_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (cnt_load),
        .load_val_i (cnt_val),
        .zero_o     (cnt_zero)
    );

    assign press      = btn_i & ~btn_q & ~lockout_q;
    assign wrong      = press & ~mole_q;
    assign hit        = press & mole_q;
    assign score_inc  = (score_q == SAT) ? score_q : score_q + 1'b1;
    assign misses_inc = (misses_q == SAT) ? misses_q : misses_q + 1'b1;
    assign next_idx   = (32'(prev_q) == N_MOLES - 1) ? '0 : prev_q + 1'b1;
    assign idx_ok     = (32'(rand_idx_i) < N_MOLES) && (rand_idx_i != prev_q);
    // Fall back to the next index on the last allowed retry so SPAWN is bounded.
    assign spawn_go   = idx_ok || (32'(retry_q) == RETRY_LIMIT - 1);
    assign idx        = idx_ok ? rand_idx_i : next_idx;
    assign start_ok   = start_i & ~game_end_i;
    assign lvl_up     = (32'(score_inc) % LEVEL_STEP == 0) && (score_inc != '0) && (32'(level_q) < MAX_LEVEL);

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state_q   <= IDLE;
            mole_q    <= '0;
            lockout_q <= '0;
            btn_q     <= '0;
            score_q   <= '0;
            misses_q  <= '0;
            level_q   <= '0;
            prev_q    <= '0;
            retry_q   <= '0;
        end else begin
            state_q   <= state_d;
            mole_q    <= mole_d;
            lockout_q <= lockout_d;
            btn_q     <= btn_i;
            score_q   <= score_d;
            misses_q  <= misses_d;
            level_q   <= level_d;
            prev_q    <= prev_d;
            retry_q   <= retry_d;
        end

    always_comb begin
        state_d   = state_q;
        mole_d    = mole_q;
        lockout_d = lockout_q & btn_i;
        score_d   = score_q;
        misses_d  = misses_q;
        level_d   = level_q;
        prev_d    = prev_q;
        retry_d   = '0;
        cnt_load  = 1'b0;
        cnt_val   = CNT_W'(PENALTY_TICKS - 1);
        case (state_q)
            IDLE, DONE: if (start_ok) begin
                state_d   = SPAWN;
                score_d   = '0;
                misses_d  = '0;
                level_d   = '0;
                lockout_d = '0;
            end
            SPAWN: if (game_end_i) begin
                state_d = DONE;
                mole_d  = '0;
            end else if (spawn_go) begin
                state_d  = UP;
                mole_d   = N_MOLES'(1) << idx;
                prev_d   = idx;
                cnt_load = 1'b1;
                cnt_val  = CNT_W'(up_ticks(MOLE_TICKS, MIN_TICKS, level_q) - 1);
            end else retry_d = retry_q + 1'b1;
            UP: if (game_end_i) begin
                state_d = DONE;
                mole_d  = '0;
            end else if (|wrong) begin
                state_d   = PENALTY;
                lockout_d = lockout_d | wrong;
                misses_d  = misses_inc;
                mole_d    = '0;
                cnt_load  = 1'b1;
            end else if (|hit) begin
                state_d = SPAWN;
                score_d = score_inc;
                level_d = level_q + LEVEL_W'(lvl_up);
                mole_d  = '0;
            end else if (cnt_zero) begin
                state_d  = SPAWN;
                misses_d = misses_inc;
                mole_d   = '0;
            end
            PENALTY: if (game_end_i) begin
                state_d = DONE;
                mole_d  = '0;
            end else if (cnt_zero) state_d = SPAWN;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mole_o    = mole_q;
        lockout_o = lockout_q;
        score_o   = score_q;
        misses_o  = misses_q;
        level_o   = level_q;
        active_o  = (state_q == SPAWN) || (state_q == UP) || (state_q == PENALTY);
    end
endmodule

// File: tb/tb_mole_round_ctrl.sv
// tb_mole_round_ctrl: directed scenarios for the mole round controller at small timing parameters.
module tb_mole_round_ctrl;
    logic       clk = 1'b0;
    logic       rst_n, start, game_end;
    logic [1:0] rand_idx;
    logic [3:0] btn, mole, lockout;
    logic [7:0] score, misses;
    logic [2:0] level;
    logic       active;
    int         n_vec = 0, n_bad = 0;

    mole_round_ctrl #(
        .N_MOLES(4), .SCORE_W(8), .MOLE_TICKS(16), .MIN_TICKS(4),
        .PENALTY_TICKS(4), .LEVEL_STEP(2), .MAX_LEVEL(7)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start), .game_end_i(game_end),
        .rand_idx_i(rand_idx), .btn_i(btn), .mole_o(mole), .lockout_o(lockout),
        .score_o(score), .misses_o(misses), .level_o(level), .active_o(active)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst_n = 1'b0; start = 1'b0; game_end = 1'b0; rand_idx = '0; btn = '0;
        #3;
        tick(2);
        rst_n = 1'b1;
    endtask

    task automatic begin_round(input logic [1:0] i);
        rand_idx = i; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
    endtask

    // Assumes the controller sits in SPAWN and i differs from the previous index.
    task automatic hit(input logic [1:0] i);
        rand_idx = i; btn = '0;
        tick();
        btn = 4'b0001 << i;
        tick();
        btn = '0;
    endtask

    initial begin
        do_reset();
        chk("rst_mole", mole, 0);
        chk("rst_lock", lockout, 0);
        chk("rst_score", score, 0);
        chk("rst_miss", misses, 0);
        chk("rst_level", level, 0);
        chk("rst_active", active, 0);

        begin_round(2);
        chk("hit_mole", mole, 4'b0100);
        chk("hit_active", active, 1);
        btn = 4'b0100;
        tick();
        chk("hit_score", score, 1);
        chk("hit_clear", mole, 0);
        rand_idx = 1;
        tick();
        chk("hit_mole2", mole, 4'b0010);
        btn = 4'b0110;
        tick();
        chk("hit_score2", score, 2);
        chk("hit_level", level, 1);
        rand_idx = 2;
        tick();
        chk("hold_mole", mole, 4'b0100);
        tick(3);
        chk("hold_score", score, 2);
        chk("hold_miss", misses, 0);
        chk("hold_up", mole, 4'b0100);

        do_reset();
        begin_round(2);
        tick(15);
        chk("to_still_up", mole, 4'b0100);
        tick();
        chk("to_clear", mole, 0);
        chk("to_miss", misses, 1);
        chk("to_score", score, 0);

        do_reset();
        begin_round(1);
        btn = 4'b1000;
        tick();
        chk("wp_miss", misses, 1);
        chk("wp_lock", lockout, 4'b1000);
        chk("wp_mole", mole, 0);
        rand_idx = 0;
        for (int k = 1; k <= 3; k++) begin
            tick();
            chk("wp_blank", mole, 0);
            chk("wp_held", lockout, 4'b1000);
        end
        tick();
        chk("wp_spawn", mole, 0);
        tick();
        chk("wp_next", mole, 4'b0001);
        btn = 4'b0000;
        tick();
        chk("wp_release", lockout, 0);
        btn = 4'b1000;
        tick();
        chk("wp_repress", misses, 2);

        do_reset();
        begin_round(1);
        btn = 4'b1010;
        tick();
        chk("sim_score", score, 0);
        chk("sim_miss", misses, 1);
        chk("sim_lock", lockout, 4'b1000);
        chk("sim_mole", mole, 0);

        do_reset();
        begin_round(3);
        chk("rej_first", mole, 4'b1000);
        btn = 4'b1000;
        tick();
        btn = 4'b0000;
        chk("rej_score", score, 1);
        tick(3);
        chk("rej_spawn4", mole, 0);
        chk("rej_active", active, 1);
        tick();
        chk("rej_forced", mole, 4'b0001);

        do_reset();
        begin_round(1);
        btn = 4'b0010;
        tick();
        btn = 4'b0000;
        hit(2);
        chk("lv_score", score, 2);
        chk("lv_level1", level, 1);
        rand_idx = 1;
        tick();
        tick(7);
        chk("lv8_up", mole, 4'b0010);
        tick();
        chk("lv8_clear", mole, 0);
        chk("lv8_miss", misses, 1);
        hit(2); hit(1); hit(2); hit(1);
        chk("lv_score6", score, 6);
        chk("lv_level3", level, 3);
        rand_idx = 2;
        tick();
        tick(3);
        chk("lvf_up", mole, 4'b0100);
        tick();
        chk("lvf_clear", mole, 0);
        chk("lvf_miss", misses, 2);
        rand_idx = 1;
        tick(2);
        chk("ge_up", mole, 4'b0010);
        game_end = 1'b1; btn = 4'b0010;
        tick();
        chk("ge_mole", mole, 0);
        chk("ge_score", score, 6);
        chk("ge_miss", misses, 2);
        chk("ge_active", active, 0);
        btn = 4'b0000; start = 1'b1;
        tick();
        chk("ge_start_ign", active, 0);
        chk("ge_level", level, 3);
        game_end = 1'b0;
        tick();
        start = 1'b0;
        chk("restart_active", active, 1);
        chk("restart_score", score, 0);
        chk("restart_level", level, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/mole_round_ctrl.md
Name: mole_round_ctrl

Overview:
- Parametrised successor to the single-mole game FSM: one round controller for N moles (buttons).
- Adds per-mole timeout with miss counting, a timed wrong-press penalty, release-based lockout, and level-based speed-up.
- Sits between the LFSR, the round timer, the synchronised button bus and the display/score drivers.
- Outputs a one-hot mole vector plus score, miss count and level.

Parameters:
- N_MOLES, 7, number of moles/buttons (2..16).
- IDX_W, $clog2(N_MOLES) (min 1), width of the random index input.
- SCORE_W, 8, width of the score and miss counters.
- MOLE_TICKS, 500000, cycles a mole stays up at level 0.
- MIN_TICKS, 50000, floor for mole-up time.
- PENALTY_TICKS, 100000, cycles the board is blanked after a wrong press.
- LEVEL_STEP, 8, hits per level increment.
- MAX_LEVEL, 7, level saturation value (level width 3).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle request to begin a round
- game_end  in  1  round timer expired (level, from the game timer)
- rand_idx  in  IDX_W  random mole index from the LFSR
- btn  in  N_MOLES  synchronised, debounced button levels
- mole  out  N_MOLES  one-hot lit mole; all-zero when none
- lockout  out  N_MOLES  buttons currently ignored
- score  out  SCORE_W  hit count
- misses  out  SCORE_W  timeouts plus wrong presses
- level  out  3  current speed level
- active  out  1  high in SPAWN, UP or PENALTY

Behaviour:
- Reset: state IDLE; mole, lockout, score, misses, level = 0; active = 0; prev_idx = 0; retry = 0.
- Edge detect: btn_q is registered each cycle. press[i] = btn[i] & ~btn_q[i] & ~lockout[i]. Only rising edges count; holding a button does nothing.
- Lockout: a bit is set by a wrong press and cleared on the first cycle its btn bit is low. It is cleared entirely on entry to SPAWN from IDLE/DONE.
- IDLE:
  - start & !game_end -> SPAWN; clear score, misses, level, lockout.
  - start while game_end is high is ignored.
- SPAWN (mole = 0):
  - Accept rand_idx if it is < N_MOLES and != prev_idx. Then mole <= 1<<rand_idx at the next edge, prev_idx <= rand_idx, load the countdown with up_ticks, go to UP.
  - Otherwise retry += 1 and stay in SPAWN.
  - On the 4th consecutive rejection, force idx = (prev_idx+1) mod N_MOLES. SPAWN therefore lasts at most 4 cycles.
- UP, priority order:
  - (a) Any wrong press, even in the same cycle as a correct press: lockout |= wrong bits, misses+1, mole <= 0, load PENALTY_TICKS, -> PENALTY.
  - (b) Correct press only: score+1, mole <= 0, -> SPAWN. The update lands at the clock edge after the rising edge is seen (1-cycle latency).
  - (c) Countdown reaches 0: misses+1, mole <= 0, -> SPAWN.
- PENALTY:
  - mole = 0; presses are ignored (only lockout release is tracked).
  - When the countdown reaches 0 -> SPAWN.
- Level:
  - After each hit, if the new score is a nonzero multiple of LEVEL_STEP, level+1, saturating at MAX_LEVEL.
  - up_ticks = max(MOLE_TICKS >> level, MIN_TICKS). It is evaluated at load time, so a level change never alters a mole already up.
- Arithmetic: score and misses saturate at 2^SCORE_W-1 and never wrap. The countdown is wide enough for max(MOLE_TICKS, PENALTY_TICKS).
- game_end:
  - Highest priority in every active state: -> DONE at the next edge, mole <= 0, counters frozen. A press in that same cycle is not counted.
  - DONE holds score, misses and level.
  - In DONE, start with game_end low -> SPAWN, with the same clears as in IDLE.
- Reset mid-round: asynchronous return to the reset values above; no partial update survives.
- Invariants:
  - mole is zero or one-hot, never multi-hot.
  - active = (state in SPAWN/UP/PENALTY).

Decomposition:
- Package mole_pkg holds:
  - the state enum (IDLE, SPAWN, UP, PENALTY, DONE);
  - the SPAWN retry limit constant (4);
  - the level width constant (3);
  - a function computing up_ticks from level.
- One sub-module, mole_countdown: loadable down-counter with load, load_val, and a zero flag. It is shared by the UP and PENALTY timing.

Test Plan:
- Parameters for all scenarios: N_MOLES=4, MOLE_TICKS=16, MIN_TICKS=4, PENALTY_TICKS=4, LEVEL_STEP=2.
- Hit: start; rand_idx=2; mole=4'b0100; pulse btn[2] -> score=1 one edge later, mole=0, SPAWN. Holding btn[2] through the next mole at idx 2 does not score.
- Timeout: mole up, no press -> mole clears after exactly 16 cycles, misses=1, score unchanged.
- Wrong press: mole=idx1; press btn[3] -> misses=1, lockout=4'b1000, mole=0 for 4 cycles. btn[3] held stays locked; release clears the bit.
- Simultaneous: btn[1] and btn[3] rise in the same cycle with mole=idx1 -> treated as wrong: score unchanged, misses+1, PENALTY.
- Rand rejection: rand_idx held at 3 (invalid repeat after idx 3) -> exactly 4 SPAWN cycles, then mole=4'b0001 (forced (3+1) mod 4).
- Level/end: 2 hits -> level=1 and next mole up 8 cycles. Further levels floor at 4 cycles. Assert game_end mid-UP with a press -> DONE, mole=0, counters frozen; start while game_end high ignored.
